// File: rtl/dco_count_reader.sv
// dco_count_reader: unwraps the sampled DCO edge count into per-cycle increments and accumulates variable phase.
module dco_count_reader #(
    parameter int CNT_W        = 7,
    parameter int PHASE_W      = 16,
    parameter int DELTA_MIN    = 1,
    parameter int DELTA_MAX    = 100,
    parameter int DELTA_INIT   = 37,
    parameter int GLITCH_LIMIT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [CNT_W-1:0]   count,
    output logic [CNT_W-1:0]   delta,
    output logic [PHASE_W-1:0] phase,
    output logic               valid,
    output logic               glitch,
    output logic               lock_lost,
    output logic [7:0]         glitch_cnt
);
    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
    localparam logic [CNT_W-1:0] D_MIN  = CNT_W'(DELTA_MIN);
    localparam logic [CNT_W-1:0] D_MAX  = CNT_W'(DELTA_MAX);
    localparam logic [CNT_W-1:0] D_INIT = CNT_W'(DELTA_INIT);
    localparam logic [7:0]       LIMIT  = 8'(GLITCH_LIMIT);
    state_t             state;
    logic [CNT_W-1:0]   count_q, prev, last_good, raw, inc;
    logic [7:0]         consec;
    logic               good, resync;
    assign raw    = count_q - prev;
    assign good   = raw >= D_MIN && raw <= D_MAX;
    assign inc    = good ? raw : last_good;
    assign resync = !good && consec + 8'd1 >= LIMIT;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count_q    <= '0;
            prev       <= '0;
            last_good  <= D_INIT;
            consec     <= '0;
            delta      <= '0;
            phase      <= '0;
            valid      <= 1'b0;
            glitch     <= 1'b0;
            lock_lost  <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            count_q <= count;
            if (state == RUN && en) begin
                valid      <= 1'b1;
                glitch     <= !good;
                lock_lost  <= resync;
                delta      <= inc;
                phase      <= phase + PHASE_W'(inc);
                // a rejected sample never becomes the reference: advance prev by the substitute
                prev       <= good ? count_q : prev + last_good;
                last_good  <= inc;
                consec     <= good ? 8'd0 : consec + 8'd1;
                glitch_cnt <= (!good && glitch_cnt != 8'hff) ? glitch_cnt + 8'd1 : glitch_cnt;
                state      <= resync ? PRIME : RUN;
            end else begin
                valid     <= 1'b0;
                glitch    <= 1'b0;
                lock_lost <= 1'b0;
                if (state == PRIME && en) begin
                    prev      <= count_q;
                    last_good <= D_INIT;
                    consec    <= '0;
                    state     <= RUN;
                end else begin
                    state <= (state == IDLE && en) ? PRIME : IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_dco_count_reader.sv
// tb_dco_count_reader: directed vector table plus randomized run against a behavioural model.
module tb_dco_count_reader;
    logic        clk = 1'b0;
    logic        rst, en;
    logic [6:0]  count;
    logic [6:0]  delta;
    logic [15:0] phase;
    logic        valid, glitch, lock_lost;
    logic [7:0]  glitch_cnt;

    dco_count_reader dut (
        .clk(clk), .rst(rst), .en(en), .count(count),
        .delta(delta), .phase(phase), .valid(valid), .glitch(glitch),
        .lock_lost(lock_lost), .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, en;
        int   cnt;
        logic v, g, ll;
        int   d, p, gc;
    } vec_t;
    vec_t tbl[15];

    int n_cmp = 0, n_err = 0;

    // model: mode 0 idle, 1 prime, 2 run; arithmetic done on plain ints
    int m_mode, m_cq, m_prev, m_lg, m_consec, m_delta, m_phase, m_gc;
    bit m_v, m_g, m_ll;

    task automatic model_step(input bit r, input bit e, input int c);
        int raw, inc;
        bit ok;
        if (r) begin
            m_mode = 0; m_cq = 0; m_prev = 0; m_lg = 37; m_consec = 0;
            m_delta = 0; m_phase = 0; m_gc = 0; m_v = 0; m_g = 0; m_ll = 0;
            return;
        end
        m_v = 0; m_g = 0; m_ll = 0;
        if (m_mode == 2 && e) begin
            raw = (m_cq - m_prev + 128) % 128;
            ok = raw >= 1 && raw <= 100;
            inc = ok ? raw : m_lg;
            m_delta = inc;
            m_phase = (m_phase + inc) % 65536;
            m_v = 1;
            m_g = !ok;
            if (ok) begin
                m_prev = m_cq; m_lg = raw; m_consec = 0;
            end else begin
                m_prev = (m_prev + m_lg) % 128;
                m_consec++;
                if (m_gc < 255) m_gc++;
            end
            m_ll = !ok && m_consec >= 3;
            m_mode = m_ll ? 1 : 2;
        end else if (m_mode == 1 && e) begin
            m_prev = m_cq; m_lg = 37; m_consec = 0; m_mode = 2;
        end else begin
            m_mode = (m_mode == 0 && e) ? 1 : 0;
        end
        m_cq = c;
    endtask

    task automatic compare(input string name, input bit v, input bit g, input bit ll,
                           input int d, input int p, input int gc);
        n_cmp++;
        if (valid !== v || glitch !== g || lock_lost !== ll || int'(delta) != d ||
            int'(phase) != p || int'(glitch_cnt) != gc) begin
            n_err++;
            $display("FAIL %s: got v=%0b g=%0b ll=%0b d=%0d p=%0d gc=%0d want v=%0b g=%0b ll=%0b d=%0d p=%0d gc=%0d",
                     name, valid, glitch, lock_lost, delta, phase, glitch_cnt, v, g, ll, d, p, gc);
        end
    endtask

    task automatic step(input string name, input bit r, input bit e, input int c);
        rst = r; en = e; count = 7'(c);
        model_step(r, e, c);
        @(posedge clk);
        #1;
        compare(name, m_v, m_g, m_ll, m_delta, m_phase, m_gc);
    endtask

    initial begin
        int cur;
        rst = 1'b1; en = 1'b0; count = '0;
        //            rst en cnt  v  g  ll d   p    gc
        tbl[0]  = '{1, 0, 0,   0, 0, 0, 0,  0,   0};
        tbl[1]  = '{0, 1, 0,   0, 0, 0, 0,  0,   0};
        tbl[2]  = '{0, 1, 37,  0, 0, 0, 0,  0,   0};
        tbl[3]  = '{0, 1, 74,  1, 0, 0, 37, 37,  0};
        tbl[4]  = '{0, 1, 50,  1, 0, 0, 37, 74,  0};
        tbl[5]  = '{0, 1, 20,  1, 1, 0, 37, 111, 1};
        tbl[6]  = '{0, 1, 57,  1, 0, 0, 37, 148, 1};
        tbl[7]  = '{0, 1, 94,  1, 0, 0, 37, 185, 1};
        tbl[8]  = '{0, 1, 94,  1, 0, 0, 37, 222, 1};
        tbl[9]  = '{0, 1, 3,   1, 1, 0, 37, 259, 2};
        tbl[10] = '{0, 1, 40,  1, 1, 0, 37, 296, 3};
        tbl[11] = '{0, 1, 10,  1, 1, 1, 37, 333, 4};
        tbl[12] = '{0, 1, 47,  0, 0, 0, 37, 333, 4};
        tbl[13] = '{0, 1, 84,  1, 0, 0, 37, 370, 4};
        tbl[14] = '{0, 1, 121, 1, 0, 0, 37, 407, 4};
        @(posedge clk);
        #1;
        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; count = 7'(tbl[i].cnt);
            model_step(tbl[i].rst, tbl[i].en, tbl[i].cnt);
            @(posedge clk);
            #1;
            compare($sformatf("vec%0d", i), tbl[i].v, tbl[i].g, tbl[i].ll, tbl[i].d, tbl[i].p, tbl[i].gc);
        end
        cur = 121;
        // steady stream crossing the 7-bit count wrap
        for (int i = 0; i < 10; i++) begin
            cur = (cur + 37) % 128;
            step("steady", 0, 1, cur);
        end
        for (int i = 0; i < 4; i++) begin
            cur = (cur + 37) % 128;
            step("en_off", 0, 0, cur);
        end
        for (int i = 0; i < 6; i++) begin
            cur = (cur + 37) % 128;
            step("en_back", 0, 1, cur);
        end
        step("rst_mid", 1, 1, 55);
        step("after_rst", 0, 0, 92);
        step("idle_hold", 0, 0, 1);
        cur = 1;
        for (int i = 0; i < 4000; i++) begin
            bit e;
            int c;
            cur = (cur + int'($urandom_range(20, 60))) % 128;
            e = ($urandom_range(0, 99) != 0);
            c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : cur;
            step("random", 0, e, c);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
